// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB LED stream blocks: channel bit positions,
// active-low colour codes and the counter-width helper.
package rgb_pkg;

    localparam int R_IDX = 2;
    localparam int B_IDX = 1;
    localparam int G_IDX = 0;

    localparam logic [2:0] RED     = 3'b011;
    localparam logic [2:0] BLUE    = 3'b101;
    localparam logic [2:0] GREEN   = 3'b110;
    localparam logic [2:0] MAGENTA = 3'b001;
    localparam logic [2:0] WHITE   = 3'b000;
    localparam logic [2:0] OFF     = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dec_state_e;

    // Bits needed to hold any value 0..max_count (at least one bit).
    function automatic int count_width(input int max_count);
        if (max_count < 1) begin
            return 1;
        end else begin
            return $clog2(max_count + 1);
        end
    endfunction

endpackage

// File: rtl/rgb_sample_tick.sv
// Sample-rate prescaler: strobes once every TICKS_PER_SAMPLE clocks while
// i_clear is low; i_clear holds the count at zero.
module rgb_sample_tick #(
    parameter int TICKS_PER_SAMPLE = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_strobe
);

    localparam int TW = (TICKS_PER_SAMPLE > 1) ? $clog2(TICKS_PER_SAMPLE) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_SAMPLE - 1);

    logic [TW-1:0] r_count;
    logic          w_at_last;

    // Strobe decode from the current count.
    always_comb begin
        w_at_last = (r_count == LAST_TICK);
        o_strobe  = ~i_clear & w_at_last;
    end

    // Prescaler counter, wraps after the strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + TW'(1);
        end
    end

endmodule

// File: rtl/rgb_duty_decoder.sv
// Recovers per-channel lit-sample counts and colour-change counts from a
// time-multiplexed RGB LED stream over fixed windows of samples.
module rgb_duty_decoder
    import rgb_pkg::*;
#(
    parameter int  TICKS_PER_SAMPLE   = 12,
    parameter int  SAMPLES_PER_WINDOW = 1000,
    parameter int  ACTIVE_LOW         = 1,
    localparam int CW                 = count_width(SAMPLES_PER_WINDOW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [2:0]    led_in,
    output logic [CW-1:0] on_count_r,
    output logic [CW-1:0] on_count_g,
    output logic [CW-1:0] on_count_b,
    output logic [CW-1:0] toggle_count,
    output logic          window_valid
);

    localparam int          IW         = $clog2(SAMPLES_PER_WINDOW);
    localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES_PER_WINDOW - 1);
    localparam logic [2:0]  DARK_CODE  = (ACTIVE_LOW != 0) ? OFF : WHITE;

    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_prev_code;
    logic          r_first;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_acc_r;
    logic [CW-1:0] r_acc_g;
    logic [CW-1:0] r_acc_b;
    logic [CW-1:0] r_acc_t;
    logic [CW-1:0] r_out_r;
    logic [CW-1:0] r_out_g;
    logic [CW-1:0] r_out_b;
    logic [CW-1:0] r_out_t;
    logic          r_valid;
    dec_state_e    r_state;

    logic          w_strobe;
    logic          w_clear;
    logic [2:0]    w_lit;
    logic          w_toggle;
    logic          w_last;
    logic [CW-1:0] w_next_r;
    logic [CW-1:0] w_next_g;
    logic [CW-1:0] w_next_b;
    logic [CW-1:0] w_next_t;

    rgb_sample_tick #(
        .TICKS_PER_SAMPLE(TICKS_PER_SAMPLE)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .o_strobe(w_strobe)
    );

    // Two-flop synchroniser; idles at the dark code so nothing reads as lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= DARK_CODE;
            r_sync2 <= DARK_CODE;
        end else begin
            r_sync1 <= led_in;
            r_sync2 <= r_sync1;
        end
    end

    // Lit decode and accumulator next values including the current sample.
    always_comb begin
        w_clear  = ~enable;
        w_lit    = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
        w_toggle = (r_sync2 != r_prev_code) & ~r_first;
        w_last   = (r_idx == LAST_IDX);
        w_next_r = r_acc_r + CW'(w_lit[R_IDX]);
        w_next_g = r_acc_g + CW'(w_lit[G_IDX]);
        w_next_b = r_acc_b + CW'(w_lit[B_IDX]);
        w_next_t = r_acc_t + CW'(w_toggle);
    end

    // IDLE/RUN control with window accumulation and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prev_code <= DARK_CODE;
            r_first     <= 1'b1;
            r_idx       <= '0;
            r_acc_r     <= '0;
            r_acc_g     <= '0;
            r_acc_b     <= '0;
            r_acc_t     <= '0;
            r_out_r     <= '0;
            r_out_g     <= '0;
            r_out_b     <= '0;
            r_out_t     <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A dropped enable discards the partial window.
            if (!enable) begin
                r_first <= 1'b1;
                r_idx   <= '0;
                r_acc_r <= '0;
                r_acc_g <= '0;
                r_acc_b <= '0;
                r_acc_t <= '0;
            end else if (w_strobe) begin
                r_prev_code <= r_sync2;
                r_first     <= 1'b0;
                if (w_last) begin
                    r_out_r <= w_next_r;
                    r_out_g <= w_next_g;
                    r_out_b <= w_next_b;
                    r_out_t <= w_next_t;
                    r_valid <= 1'b1;
                    r_idx   <= '0;
                    r_acc_r <= '0;
                    r_acc_g <= '0;
                    r_acc_b <= '0;
                    r_acc_t <= '0;
                end else begin
                    r_idx   <= r_idx + IW'(1);
                    r_acc_r <= w_next_r;
                    r_acc_g <= w_next_g;
                    r_acc_b <= w_next_b;
                    r_acc_t <= w_next_t;
                end
            end else begin
                r_idx <= r_idx;
            end
        end
    end

    assign on_count_r   = r_out_r;
    assign on_count_g   = r_out_g;
    assign on_count_b   = r_out_b;
    assign toggle_count = r_out_t;
    assign window_valid = r_valid;

endmodule

// File: tb/tb_rgb_duty_decoder.sv
// Directed bench for rgb_duty_decoder with 2 ticks/sample, 10 samples/window.
module tb_rgb_duty_decoder;
    import rgb_pkg::*;

    localparam int TPS = 2;
    localparam int SPW = 10;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [2:0]    led_in;
    logic [CW-1:0] on_count_r;
    logic [CW-1:0] on_count_g;
    logic [CW-1:0] on_count_b;
    logic [CW-1:0] toggle_count;
    logic          window_valid;

    int   n_checks = 0;
    int   n_errors = 0;
    logic alt_mode = 1'b0;
    int   ph       = 0;
    int   cyc;
    logic seen;

    always #5 clk = ~clk;

    rgb_duty_decoder #(
        .TICKS_PER_SAMPLE  (TPS),
        .SAMPLES_PER_WINDOW(SPW),
        .ACTIVE_LOW        (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .led_in      (led_in),
        .on_count_r  (on_count_r),
        .on_count_g  (on_count_g),
        .on_count_b  (on_count_b),
        .toggle_count(toggle_count),
        .window_valid(window_valid)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_counts(input string tag, input int r, input int g, input int b, input int t);
        chk({tag, "_r"}, int'(on_count_r), r);
        chk({tag, "_g"}, int'(on_count_g), g);
        chk({tag, "_b"}, int'(on_count_b), b);
        chk({tag, "_tog"}, int'(toggle_count), t);
    endtask

    // One clock; in alternating mode the LED code flips every two clocks.
    task automatic step();
        @(negedge clk);
        if (alt_mode) begin
            ph++;
            if (ph == 2) begin
                ph = 0;
                led_in = (led_in == RED) ? BLUE : RED;
            end
        end
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (window_valid) begin
                cycles = i + 1;
                return;
            end
        end
        chk("valid_timeout", 0, 1);
    endtask

    task automatic start(input logic [2:0] code);
        enable   = 1'b0;
        alt_mode = 1'b0;
        step();
        led_in = code;
        repeat (4) step();
        enable = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        led_in = OFF;
        repeat (3) @(negedge clk);
        chk_counts("reset", 0, 0, 0, 0);
        chk("reset_valid", int'(window_valid), 0);
        rst_n = 1'b1;

        start(RED);
        wait_valid(cyc);
        chk("red_latency", cyc, 20);
        chk_counts("red1", 10, 0, 0, 0);
        step();
        chk("valid_one_cycle", int'(window_valid), 0);
        wait_valid(cyc);
        chk("red_period", cyc, 19);
        chk_counts("red2", 10, 0, 0, 0);

        start(RED);
        alt_mode = 1'b1;
        ph       = 1;
        wait_valid(cyc);
        chk_counts("alt1", 5, 0, 5, 9);
        wait_valid(cyc);
        chk_counts("alt2", 5, 0, 5, 10);

        start(WHITE);
        wait_valid(cyc);
        chk_counts("white", 10, 10, 10, 0);

        start(OFF);
        wait_valid(cyc);
        chk_counts("off", 0, 0, 0, 0);

        start(RED);
        seen = 1'b0;
        repeat (12) begin
            step();
            if (window_valid) seen = 1'b1;
        end
        chk("partial_no_valid", int'(seen), 0);
        enable = 1'b0;
        led_in = GREEN;
        repeat (3) step();
        chk_counts("partial_hold", 0, 0, 0, 0);
        enable = 1'b1;
        wait_valid(cyc);
        chk("green_latency", cyc, 20);
        chk_counts("green", 0, 10, 0, 0);

        start(RED);
        wait_valid(cyc);
        chk_counts("pre_rst", 10, 0, 0, 0);
        repeat (10) step();
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk_counts("mid_rst", 0, 0, 0, 0);
        chk("mid_rst_valid", int'(window_valid), 0);
        seen = 1'b0;
        repeat (4) begin
            step();
            if (window_valid) seen = 1'b1;
        end
        chk("rst_no_valid", int'(seen), 0);
        rst_n = 1'b1;
        start(BLUE);
        wait_valid(cyc);
        chk("post_rst_latency", cyc, 20);
        chk_counts("post_rst", 0, 0, 10, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rgb_duty_decoder.md
Name: rgb_duty_decoder

Overview:
Receive-side counterpart of the rainbow blur driver: samples a time-multiplexed 3-bit RGB LED stream and recovers per-channel on-time and colour-switch activity over fixed measurement windows. Used as an on-chip self-test monitor tapped onto the LED pins, and as the measurement core in the blur-driver bench. Reports one result set per window with a single-cycle valid strobe.

Parameters:
TICKS_PER_SAMPLE, 12, clk cycles between samples (1 us at 12 MHz); legal range is 1 or more.
SAMPLES_PER_WINDOW, 1000, samples per measurement window; legal range is 2 or more.
ACTIVE_LOW, 1, 1 means an LED bit value of 0 is lit; 0 means a bit value of 1 is lit.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  measurement enable; low means idle, with accumulators cleared
led_in  in  3  LED stream with bit2=R, bit1=B, bit0=G (polarity set by ACTIVE_LOW)
on_count_r  out  CW  lit-sample count for R in the last completed window, where CW=$clog2(SAMPLES_PER_WINDOW+1)
on_count_g  out  CW  lit-sample count for G
on_count_b  out  CW  lit-sample count for B
toggle_count  out  CW  number of samples whose 3-bit code differed from the previous sample
window_valid  out  1  one-cycle pulse when all outputs have been updated

Behaviour:
- Reset (async, rst_n low):
  - Outputs: all counts 0, window_valid 0.
  - Internal state: synchroniser flops at the "all off" code (3'b111 when ACTIVE_LOW=1, else 3'b000); prescaler 0; sample index 0; accumulators 0; first_flag=1.
- Input path:
  - led_in passes through a 2-flop synchroniser.
  - Everything below uses only the synchronised value s.
  - Latency from a led_in change to s is 2 cycles.
- Lit decode per bit: lit = ACTIVE_LOW ? ~s[i] : s[i].
- Prescaler:
  - Counts 0..TICKS_PER_SAMPLE-1 while enable=1.
  - The sample strobe asserts in the cycle where the count equals TICKS_PER_SAMPLE-1; the count then wraps to 0.
  - With TICKS_PER_SAMPLE=1 the strobe is asserted every cycle.
- On each strobe:
  - Each channel accumulator increments when that bit is lit.
  - The toggle accumulator increments when s != prev_code and first_flag=0.
  - Then prev_code<=s and first_flag<=0.
  - The sample index increments.
- Window end, on the strobe where the sample index = SAMPLES_PER_WINDOW-1:
  - Output registers load the accumulator values including the current sample.
  - Accumulators and the sample index clear to 0.
  - window_valid=1 in the next clk cycle only.
- Toggles across a window boundary are counted in the new window; prev_code is not cleared at the boundary.
- Counts never exceed SAMPLES_PER_WINDOW, so no saturation logic is needed. toggle_count is at most SAMPLES_PER_WINDOW-1 in the first window and at most SAMPLES_PER_WINDOW afterwards.
- enable=0:
  - Prescaler, sample index and accumulators are held at 0; first_flag<=1; no strobe and no valid.
  - Output registers keep their last values.
  - Dropping enable mid-window discards the partial window.
  - The first strobe after enable rises occurs TICKS_PER_SAMPLE cycles later.
- Reset mid-window: everything returns to reset values immediately, including the outputs; no valid pulse.
- States: IDLE (enable=0) and RUN. The window-end and window_valid logic is a one-cycle registered pulse, not a separate state.

Decomposition:
- Shared package rgb_pkg holds:
  - Channel index constants: R_IDX=2, B_IDX=1, G_IDX=0.
  - Active-low colour codes: RED=3'b011, BLUE=3'b101, GREEN=3'b110, MAGENTA=3'b001, WHITE=3'b000, OFF=3'b111.
  - A count-width function.
- Sub-module rgb_sample_tick holds the prescaler and strobe with a clear input. It is reused by the blur driver rework.

Test Plan:
- Use TICKS_PER_SAMPLE=2, SAMPLES_PER_WINDOW=10, ACTIVE_LOW=1 for every scenario.
- Constant RED (3'b011), enable high -> after 20 cycles plus sync latency, window_valid pulses once; r=10, g=0, b=0, toggle=0. The second window gives the same values.
- led_in alternates RED/BLUE on every sample -> r=5, b=5, g=0; toggle=9 in the first window and 10 in the second.
- Constant WHITE (3'b000) -> r=g=b=10, toggle=0. Constant OFF (3'b111) -> all counts 0.
- Drop enable after 6 samples, re-raise it, then drive 10 samples of GREEN -> no valid during the partial window; the next result is g=10, r=b=0, toggle=0.
- Assert rst_n low at sample 5 of the second window -> outputs read 0 immediately and window_valid stays 0. After release, the first window reports fresh counts.
